add_sub_serial: RTL and testbench

- Parametrised multi-cycle adder/subtractor. Processes two WIDTH-bit operands DIGIT bits per clock through a registered carry chain. Each digit uses the same full-adder equations as the team's one-bit adder cell.
- Sits between control logic and datapath registers where area matters more than latency.
- Start/busy/done handshake.
- Adds features the combinational cell lacks: subtract mode, signed overflow flag, width-generic operation.

---
 rtl/add_sub_serial.sv | 135 +++++++++++++
 tb/tb_add_sub_serial.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per clock
// through a registered carry, with a start/busy/done handshake.
module add_sub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("add_sub_serial: DIGIT must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic [KW-1:0]    k_q, k_d;

    logic [DIGIT:0]       chain;
    logic [DIGIT-1:0]     digit_sum;
    logic [WIDTH+DIGIT-1:0] shifted;

    // Full-adder slices for the digit at the bottom of the operand shift registers.
    always_comb begin
        chain     = '0;
        digit_sum = '0;
        chain[0]  = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            digit_sum[i] = a_q[i] ^ b_q[i] ^ chain[i];
            chain[i+1]   = (a_q[i] & b_q[i]) | (a_q[i] & chain[i]) | (b_q[i] & chain[i]);
        end
        shifted = {digit_sum, sum_q} >> DIGIT;
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        result_d   = result_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        k_d        = k_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                sum_d   = shifted[WIDTH-1:0];
                carry_d = chain[DIGIT];
                k_d     = k_q + KW'(1);
                // The last digit holds the MSB, so its carries give the signed overflow.
                if (k_q == K_LAST) begin
                    result_d   = shifted[WIDTH-1:0];
                    cout_d     = chain[DIGIT];
                    overflow_d = chain[DIGIT] ^ chain[DIGIT-1];
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            result_q   <= result_d;
            carry_q    <= carry_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            k_q        <= k_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// Scoreboard bench for add_sub_serial: three configurations (8x1, 8x4, 16x4)
// driven with hand-computed directed vectors.
module tb_add_sub_serial;

    typedef struct {
        logic [15:0] r;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    logic        start0 = 1'b0, sub0 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0;
    logic        busy0, done0, cout0, ovf0;
    logic [7:0]  res0;

    logic        start1 = 1'b0, sub1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, cout1, ovf1;
    logic [7:0]  res1;

    logic        start2 = 1'b0, sub2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        busy2, done2, cout2, ovf2;
    logic [15:0] res2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks_total  = 0;
    int checks_passed = 0;

    add_sub_serial #(.WIDTH(8), .DIGIT(1)) dut8x1 (
        .clk(clk), .reset(reset), .start(start0), .sub(sub0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .result(res0), .cout(cout0), .overflow(ovf0)
    );

    add_sub_serial #(.WIDTH(8), .DIGIT(4)) dut8x4 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1), .overflow(ovf1)
    );

    add_sub_serial #(.WIDTH(16), .DIGIT(4)) dut16x4 (
        .clk(clk), .reset(reset), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .overflow(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic getStatus(input int which, output logic bz, output logic dn);
        case (which)
            0:       begin bz = busy0; dn = done0; end
            1:       begin bz = busy1; dn = done1; end
            default: begin bz = busy2; dn = done2; end
        endcase
    endtask

    // Pops the oldest expectation for a DUT and compares the completed result.
    task automatic scoreboardPop(input int which, input logic [15:0] r, input logic c, input logic o);
        exp_t e;
        int   n;
        n = (which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            checkOutput($sformatf("unexpected_done_dut%0d", which), 32'd1, 32'd0);
        end else begin
            case (which)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            checkOutput($sformatf("result_dut%0d", which), {16'h0, r}, {16'h0, e.r});
            checkOutput($sformatf("cout_dut%0d", which), {31'h0, c}, {31'h0, e.c});
            checkOutput($sformatf("overflow_dut%0d", which), {31'h0, o}, {31'h0, e.o});
        end
    endtask

    always @(negedge clk) if (done0) scoreboardPop(0, {8'h0, res0}, cout0, ovf0);
    always @(negedge clk) if (done1) scoreboardPop(1, {8'h0, res1}, cout1, ovf1);
    always @(negedge clk) if (done2) scoreboardPop(2, res2, cout2, ovf2);

    // Raises start for one accepting edge, then scrambles the operand inputs.
    task automatic applyStimulus(input int which, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic push,
                                 input logic [15:0] er, input logic ec, input logic eo);
        exp_t e;
        e.r = er; e.c = ec; e.o = eo;
        @(posedge clk); #1;
        case (which)
            0:       begin start0 = 1'b1; a0 = a[7:0]; b0 = b[7:0]; sub0 = s; if (push) q0.push_back(e); end
            1:       begin start1 = 1'b1; a1 = a[7:0]; b1 = b[7:0]; sub1 = s; if (push) q1.push_back(e); end
            default: begin start2 = 1'b1; a2 = a; b2 = b; sub2 = s; if (push) q2.push_back(e); end
        endcase
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        a0 = 8'($urandom); b0 = 8'($urandom); sub0 = ~sub0;
        a1 = 8'($urandom); b1 = 8'($urandom); sub1 = ~sub1;
        a2 = 16'($urandom); b2 = 16'($urandom); sub2 = ~sub2;
    endtask

    task automatic waitDone(input int which, input int exp_busy);
        int   nb;
        int   guard;
        logic bz, dn;
        nb = 0;
        guard = 0;
        dn = 1'b0;
        while (!dn && guard < 40) begin
            @(negedge clk);
            getStatus(which, bz, dn);
            if (!dn && bz) nb++;
            guard++;
        end
        checkOutput($sformatf("done_seen_dut%0d", which), {31'h0, dn}, 32'd1);
        checkOutput($sformatf("busy_cycles_dut%0d", which), nb, exp_busy);
        @(negedge clk);
        getStatus(which, bz, dn);
        checkOutput($sformatf("done_one_cycle_dut%0d", which), {31'h0, dn}, 32'd0);
    endtask

    initial begin
        int   d1, d2, guard;
        logic stable, saw_busy;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", {31'h0, busy0}, 32'd0);
        checkOutput("reset_done", {31'h0, done0}, 32'd0);
        checkOutput("reset_result", {24'h0, res0}, 32'd0);
        checkOutput("reset_flags", {30'h0, cout0, ovf0}, 32'd0);
        checkOutput("reset_others", {busy1, done1, cout1, ovf1, busy2, done2, cout2, ovf2, res1, res2},
                    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(0, 16'd200, 16'd100, 1'b0, 1'b1, 16'd44, 1'b1, 1'b0);
        waitDone(0, 8);
        applyStimulus(0, 16'd100, 16'd100, 1'b0, 1'b1, 16'hC8, 1'b0, 1'b1);
        waitDone(0, 8);
        applyStimulus(0, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);
        waitDone(0, 8);
        applyStimulus(0, 16'd7, 16'd7, 1'b1, 1'b1, 16'h00, 1'b1, 1'b0);
        waitDone(0, 8);
        applyStimulus(0, 16'd5, 16'd7, 1'b1, 1'b1, 16'hFE, 1'b0, 1'b0);
        waitDone(0, 8);

        applyStimulus(1, 16'hFF, 16'h01, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0);
        waitDone(1, 2);
        applyStimulus(1, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);
        waitDone(1, 2);
        applyStimulus(2, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        waitDone(2, 4);

        // Start held high: operands changed mid-run must not leak into the first result.
        @(posedge clk); #1;
        start0 = 1'b1; a0 = 8'd3; b0 = 8'd4; sub0 = 1'b0;
        q0.push_back('{r: 16'd7, c: 1'b0, o: 1'b0});
        q0.push_back('{r: 16'd110, c: 1'b0, o: 1'b0});
        @(posedge clk); #1;
        a0 = 8'd50; b0 = 8'd60;
        stable = 1'b1;
        guard = 0;
        while (!done0 && guard < 40) begin
            @(negedge clk);
            if (busy0 && res0 !== 8'hFE) stable = 1'b0;
            guard++;
        end
        d1 = cyc;
        checkOutput("held_result_stable_run1", {31'h0, stable}, 32'd1);
        guard = 0;
        while (!busy0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        stable = 1'b1;
        guard = 0;
        while (!done0 && guard < 40) begin
            @(negedge clk);
            if (busy0 && res0 !== 8'd7) stable = 1'b0;
            guard++;
        end
        d2 = cyc;
        checkOutput("held_result_stable_run2", {31'h0, stable}, 32'd1);
        checkOutput("done_spacing", d2 - d1, 32'd10);

        // Reset in the middle of a run abandons it and clears the outputs.
        applyStimulus(0, 16'd9, 16'd9, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midrun_reset_busy_done", {30'h0, busy0, done0}, 32'd0);
        checkOutput("midrun_reset_result", {24'h0, res0}, 32'd0);
        checkOutput("midrun_reset_flags", {30'h0, cout0, ovf0}, 32'd0);
        applyStimulus(0, 16'd1, 16'd1, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0);
        waitDone(0, 8);

        // Start coinciding with reset is not accepted.
        @(posedge clk); #1;
        reset = 1'b1; start0 = 1'b1; a0 = 8'd1; b0 = 8'd1; sub0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; start0 = 1'b0;
        saw_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy0 || done0) saw_busy = 1'b1;
        end
        checkOutput("start_with_reset_ignored", {31'h0, saw_busy}, 32'd0);

        guard = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("scoreboard_drained", q0.size() + q1.size() + q2.size(), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
